// File: rtl/bwt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bwt_pkg
//  Description : Shared types and constants for the BWT job scheduler.
//                Holds the scheduler FSM state encoding, the default string
//                length and the matching bus width, plus an owner decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package bwt_pkg;

    localparam int STRING_LEN = 32;
    localparam int STR_W      = STRING_LEN * 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Requester index -> one-hot requester vector.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bwt_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bwt_rr_arb
//  Description : Two-requester round-robin grant. The requester selected by
//                prio wins when it is valid; otherwise the other requester is
//                granted if valid. Grant is one-hot or zero.
//  Ports       : req   [1:0] in  - request vector
//                prio        in  - index of the requester holding priority
//                grant [1:0] out - one-hot grant (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module bwt_rr_arb (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    logic w_hi_valid;
    logic w_lo_valid;

    assign w_hi_valid = prio ? req[1] : req[0];
    assign w_lo_valid = prio ? req[0] : req[1];

    always_comb begin
        grant = 2'b00;
        if (w_hi_valid) begin
            grant = prio ? 2'b10 : 2'b01;
        end else if (w_lo_valid) begin
            grant = prio ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bwt_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bwt_job_sched
//  Description : Schedules Burrows-Wheeler-transform jobs from two requesters
//                onto a single sort engine, one job in flight. Requests are
//                granted round-robin; the winning string is latched, handed
//                to the engine with a one-cycle start pulse, and the engine
//                result is returned to the job owner with a valid/ready
//                handshake.
//  Optional    : `define BWT_TIMEOUT_EN adds a RUN-state watchdog; after
//                TIMEOUT_CYCLES RUN cycles without eng_done the job is
//                answered with rsp_err = 1 and rsp_data = 0.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                req_valid/req_ready[1:0] - per-requester job handshake
//                req_data_0/req_data_1    - input strings (char k at [8k+7:8k])
//                rsp_valid/rsp_ready[1:0] - per-requester result handshake
//                rsp_data, rsp_err        - result string, timeout flag
//                eng_start, eng_data      - engine launch pulse and string
//                eng_done, eng_result     - engine completion and output
//                busy                     - scheduler not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module bwt_job_sched
    import bwt_pkg::*;
#(
    parameter int STRING_LEN     = bwt_pkg::STRING_LEN,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [STRING_LEN*8-1:0] req_data_0,
    input  logic [STRING_LEN*8-1:0] req_data_1,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [STRING_LEN*8-1:0] rsp_data,
    output logic                    rsp_err,
    output logic                    eng_start,
    output logic [STRING_LEN*8-1:0] eng_data,
    input  logic                    eng_done,
    input  logic [STRING_LEN*8-1:0] eng_result,
    output logic                    busy
);

    localparam int c_STR_W = STRING_LEN * 8;

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_prio;
    logic                r_owner;
    logic [c_STR_W-1:0]  r_job;
    logic [c_STR_W-1:0]  r_rsp_data;
    logic [1:0]          w_grant;
    logic [1:0]          w_req_ready;
    logic                w_accept;
    logic                w_rsp_fire;
    logic                w_timeout;

    bwt_rr_arb u_arb (
        .req   (req_valid),
        .prio  (r_prio),
        .grant (w_grant)
    );

    // Grants are only offered in IDLE, and never while reset is asserted so
    // that no handshake can appear to complete during reset.
    assign w_req_ready = (r_state == ST_IDLE && !rst) ? w_grant : 2'b00;
    assign w_accept    = |(req_valid & w_req_ready);
    assign w_rsp_fire  = (r_state == ST_RESP) && rsp_ready[r_owner];

`ifdef BWT_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_wdog;
    logic [c_CNT_W-1:0] w_wdog_next;
    logic               r_rsp_err;

    assign w_wdog_next = r_wdog + 1'b1;
    // Fires in the RUN cycle whose increment reaches the limit; eng_done in
    // that same cycle takes precedence in the next-state and datapath logic.
    assign w_timeout   = (r_state == ST_RUN) && !eng_done &&
                         (w_wdog_next == c_CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == ST_LAUNCH) begin
                r_wdog <= '0;
            end else if (r_state == ST_RUN) begin
                r_wdog <= w_wdog_next;
            end
            if (r_state == ST_IDLE && w_accept) begin
                r_rsp_err <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (eng_done) begin
                    r_rsp_err <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign rsp_err      = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)              w_state_nx = ST_LAUNCH;
            ST_LAUNCH:                            w_state_nx = ST_RUN;
            ST_RUN:    if (eng_done || w_timeout) w_state_nx = ST_RESP;
            ST_RESP:   if (w_rsp_fire)            w_state_nx = ST_IDLE;
            default:                              w_state_nx = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Job / result datapath and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_job      <= '0;
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_job   <= w_req_ready[1] ? req_data_1 : req_data_0;
                        r_owner <= w_req_ready[1];
                    end
                end
                ST_RUN: begin
                    if (eng_done) begin
                        r_rsp_data <= eng_result;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                    end
                end
                ST_RESP: begin
                    // Priority passes to the other requester only once the
                    // job is fully delivered.
                    if (w_rsp_fire) begin
                        r_prio <= ~r_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == ST_RESP) ? owner_onehot(r_owner) : 2'b00;
    assign rsp_data  = r_rsp_data;
    assign eng_start = (r_state == ST_LAUNCH);
    assign eng_data  = r_job;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bwt_job_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bwt_job_sched
//  Description : Self-checking bench for bwt_job_sched. Directed sequence of
//                jobs with random strings, engine results, latencies and
//                back-pressure; expected grants and results come from a
//                round-robin ownership model and the values the bench itself
//                hands to the engine. Define BWT_TIMEOUT_EN to also cover the
//                watchdog with TIMEOUT_CYCLES = 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bwt_job_sched;

    localparam int STRING_LEN = 32;
    localparam int STR_W      = STRING_LEN * 8;
`ifdef BWT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [STR_W-1:0] req_data_0;
    logic [STR_W-1:0] req_data_1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [STR_W-1:0] rsp_data;
    logic             rsp_err;
    logic             eng_start;
    logic [STR_W-1:0] eng_data;
    logic             eng_done;
    logic [STR_W-1:0] eng_result;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: who holds round-robin priority, and the string
    // each requester is currently offering.
    int               m_prio = 0;
    logic [STR_W-1:0] cur_data [2];

    bwt_job_sched #(
        .STRING_LEN     (STRING_LEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data_0 (req_data_0),
        .req_data_1 (req_data_1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [STR_W-1:0] obs,
                         input logic [STR_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [STR_W-1:0] rand_str();
        logic [STR_W-1:0] v;
        for (int k = 0; k < STR_W / 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [STR_W-1:0] banana_str();
        logic [STR_W-1:0] v;
        string s;
        s = "banana$";
        v = '0;
        for (int k = 0; k < s.len(); k++) v[8*k +: 8] = s[k];
        return v;
    endfunction

    function automatic logic [1:0] oh(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Runs one job to completion. Called at a negedge with the DUT in IDLE.
    //   vmask   : requesters asserting req_valid this time
    //   d       : RUN cycles before eng_done (done in RUN cycle d+1)
    //   bp      : cycles the owner withholds rsp_ready
    //   spur    : pulse eng_done during LAUNCH (must be ignored)
    //   use_ban : offer "banana$" from new requesters
    //   no_done : never assert eng_done (watchdog case)
    task automatic do_job(input logic [1:0] vmask, input int d, input int bp,
                          input bit spur, input bit use_ban, input bit no_done);
        int               own;
        int               waitc;
        logic [STR_W-1:0] exp_str;
        logic [STR_W-1:0] res;
        logic [STR_W-1:0] exp_data;
        logic             exp_err;

        for (int i = 0; i < 2; i++)
            if (vmask[i] && !req_valid[i])
                cur_data[i] = use_ban ? banana_str() : rand_str();
        req_data_0 = cur_data[0];
        req_data_1 = cur_data[1];
        req_valid  = vmask;
        own        = vmask[m_prio] ? m_prio : 1 - m_prio;
        exp_str    = cur_data[own];
        #1;
        check("grant", STR_W'(req_ready), STR_W'(oh(own)));
        check("idle_busy", STR_W'(busy), STR_W'(1'b0));

        // LAUNCH
        step();
        req_valid[own] = 1'b0;
        eng_done   = spur;
        eng_result = rand_str();
        #1;
        check("launch_start", STR_W'(eng_start), STR_W'(1'b1));
        check("launch_ready", STR_W'(req_ready), STR_W'(2'b00));
        check("launch_data", eng_data, exp_str);
        check("launch_busy", STR_W'(busy), STR_W'(1'b1));

        // RUN cycle 1
        step();
        eng_done = 1'b0;
        #1;
        check("run_start", STR_W'(eng_start), STR_W'(1'b0));
        check("run_rsp", STR_W'(rsp_valid), STR_W'(2'b00));

        if (no_done) begin
            waitc = 0;
            while (rsp_valid == 2'b00 && waitc < 200) begin
                waitc++;
                step();
                #1;
            end
            check("wdog_cycles", STR_W'(waitc), STR_W'(TO));
            exp_data = '0;
            exp_err  = 1'b1;
        end else begin
            for (int j = 0; j < d; j++) begin
                check("run_idle_rsp", STR_W'(rsp_valid), STR_W'(2'b00));
                check("run_ready", STR_W'(req_ready), STR_W'(2'b00));
                step();
            end
            res        = rand_str();
            eng_done   = 1'b1;
            eng_result = res;
            step();
            eng_done   = 1'b0;
            eng_result = rand_str();
            #1;
            exp_data = res;
            exp_err  = 1'b0;
        end
        check("rsp_valid", STR_W'(rsp_valid), STR_W'(oh(own)));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", STR_W'(rsp_err), STR_W'(exp_err));
        check("resp_eng_data", eng_data, exp_str);

        // Back-pressure: only the non-owner says ready, which must not count.
        rsp_ready = oh(1 - own);
        for (int j = 0; j < bp; j++) begin
            step();
            #1;
            check("bp_valid", STR_W'(rsp_valid), STR_W'(oh(own)));
            check("bp_data", rsp_data, exp_data);
            check("bp_ready", STR_W'(req_ready), STR_W'(2'b00));
        end
        rsp_ready = oh(own);
        step();
        rsp_ready = 2'b00;
        #1;
        check("done_busy", STR_W'(busy), STR_W'(1'b0));
        check("done_valid", STR_W'(rsp_valid), STR_W'(2'b00));
        m_prio = 1 - own;
    endtask

    initial begin
        int d_ban;
        rst        = 1'b1;
        req_valid  = 2'b11;
        req_data_0 = '0;
        req_data_1 = '0;
        rsp_ready  = 2'b00;
        eng_done   = 1'b0;
        eng_result = '0;
        cur_data[0] = rand_str();
        cur_data[1] = rand_str();
        req_data_0 = cur_data[0];
        req_data_1 = cur_data[1];
        step();
        step();
        #1;
        check("rst_ready", STR_W'(req_ready), STR_W'(2'b00));
        check("rst_busy", STR_W'(busy), STR_W'(1'b0));
        check("rst_rsp_valid", STR_W'(rsp_valid), STR_W'(2'b00));
        check("rst_start", STR_W'(eng_start), STR_W'(1'b0));
        check("rst_rsp_data", rsp_data, '0);
        check("rst_eng_data", eng_data, '0);
        check("rst_err", STR_W'(rsp_err), STR_W'(1'b0));
        step();
        rst = 1'b0;

        // Contention from reset: req0 first, then req0 re-requests while req1
        // is still pending -> req1 goes next, then req0.
        do_job(2'b11, 3, 2, 1'b0, 1'b0, 1'b0);
        do_job(2'b11, 2, 0, 1'b0, 1'b0, 1'b0);
        do_job(2'b01, 1, 0, 1'b0, 1'b0, 1'b0);

        // Single "banana$" job with a long engine latency and 10-cycle stall.
`ifdef BWT_TIMEOUT_EN
        d_ban = 10;
`else
        d_ban = 19;
`endif
        do_job(2'b01, d_ban, 10, 1'b1, 1'b1, 1'b0);

        // Randomised jobs.
        for (int n = 0; n < 8; n++) begin
            do_job(req_valid | 2'($urandom_range(1, 3)), $urandom_range(0, 12),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        // Drain any pending requester.
        if (req_valid != 2'b00) do_job(req_valid, 0, 0, 1'b0, 1'b0, 1'b0);

        // Spurious eng_done while idle.
        req_valid = 2'b00;
        eng_done  = 1'b1;
        step();
        step();
        eng_done = 1'b0;
        #1;
        check("spur_idle_busy", STR_W'(busy), STR_W'(1'b0));
        check("spur_idle_rsp", STR_W'(rsp_valid), STR_W'(2'b00));

        // Reset mid-RUN. Make req0 finish last so priority sits with req1,
        // then abort a req1 job.
        do_job(2'b01, 1, 0, 1'b0, 1'b0, 1'b0);
        cur_data[1] = rand_str();
        req_data_1  = cur_data[1];
        req_valid   = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        step();
        #1;
        check("pre_rst_busy", STR_W'(busy), STR_W'(1'b1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        m_prio = 0;
        check("mid_rst_busy", STR_W'(busy), STR_W'(1'b0));
        check("mid_rst_rsp", STR_W'(rsp_valid), STR_W'(2'b00));
        check("mid_rst_eng_data", eng_data, '0);
        check("mid_rst_rsp_data", rsp_data, '0);
        check("mid_rst_start", STR_W'(eng_start), STR_W'(1'b0));
        eng_done = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            #1;
            check("post_rst_quiet", STR_W'(rsp_valid), STR_W'(2'b00));
        end
        eng_done = 1'b0;
        do_job(2'b11, 2, 1, 1'b0, 1'b0, 1'b0);
        do_job(2'b10, 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef BWT_TIMEOUT_EN
        // Watchdog expiry, then done arriving in the 16th RUN cycle.
        do_job(2'b01, 0, 2, 1'b0, 1'b0, 1'b1);
        do_job(2'b10, TO - 1, 0, 1'b0, 1'b0, 1'b0);
        do_job(2'b01, TO - 2, 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global guard so the bench cannot hang.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
